// File: rtl/apb_req_master_pkg.sv
// -----------------------------------------------------------------------------
// apb_req_master_pkg
// Shared types and helpers for the req/gnt/rvalid to APB3 master bridge.
//   apb_state_e    : FSM state encoding (IDLE, SETUP, ACCESS)
//   cnt_width()    : width of a counter that must reach a given limit
//   TIMEOUT_CNT_W  : counter width for the default timeout limit
// Optional feature macro: APB_REQ_MASTER_TIMEOUT_EN (see apb_req_master.sv).
// -----------------------------------------------------------------------------
package apb_req_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  localparam int unsigned TIMEOUT_CYCLES_DEF = 255;

  // Width large enough to hold the value `limit` itself.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int unsigned TIMEOUT_CNT_W = $clog2(TIMEOUT_CYCLES_DEF + 1);

endpackage

// File: rtl/apb_req_master_if.sv
// -----------------------------------------------------------------------------
// apb_req_master_if
// Bundles the request port (req/gnt/rvalid) and the APB3 master port.
//   master : view used by the bridge (drives gnt/rvalid/rdata/err and APB outs)
//   slave  : view used by the environment (requester + APB slave model)
// Handshake rules:
//   A request transfers when req_i && gnt_o are both high in the same cycle;
//   request inputs are ignored otherwise. rvalid_o is a single-cycle pulse
//   with rdata_o/err_o, which then hold until the next response. An APB
//   transfer completes when psel_o && penable_o && pready_i.
// -----------------------------------------------------------------------------
interface apb_req_master_if #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32
);
  logic                      req_i;
  logic                      gnt_o;
  logic                      we_i;
  logic [APB_ADDR_WIDTH-1:0] addr_i;
  logic [APB_DATA_WIDTH-1:0] wdata_i;
  logic                      rvalid_o;
  logic [APB_DATA_WIDTH-1:0] rdata_o;
  logic                      err_o;
  logic [APB_ADDR_WIDTH-1:0] paddr_o;
  logic [APB_DATA_WIDTH-1:0] pwdata_o;
  logic                      pwrite_o;
  logic                      psel_o;
  logic                      penable_o;
  logic [APB_DATA_WIDTH-1:0] prdata_i;
  logic                      pready_i;
  logic                      pslverr_i;

  modport master (
    input  req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
    output gnt_o, rvalid_o, rdata_o, err_o,
           paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );

  modport slave (
    output req_i, we_i, addr_i, wdata_i, prdata_i, pready_i, pslverr_i,
    input  gnt_o, rvalid_o, rdata_o, err_o,
           paddr_o, pwdata_o, pwrite_o, psel_o, penable_o
  );
endinterface

// File: rtl/apb_req_master_timeout_cnt.sv
// -----------------------------------------------------------------------------
// apb_req_timeout_cnt
// ACCESS-phase wait counter with limit compare.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : high in the cycle before ACCESS is entered (SETUP)
//   access_i      : FSM is in ACCESS
//   pready_i      : APB ready
//   hit_o         : this ACCESS cycle is the TIMEOUT_CYCLES-th wait cycle
// Used only when APB_REQ_MASTER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module apb_req_timeout_cnt
  import apb_req_master_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clear_i,
  input  logic access_i,
  input  logic pready_i,
  output logic hit_o
);
  localparam int unsigned CNT_W = cnt_width(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;

  // cnt_q counts wait cycles already spent; the current cycle is the
  // (cnt_q+1)-th, so the limit is reached when cnt_q == TIMEOUT_CYCLES-1.
  assign hit_o = access_i && !pready_i && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (access_i && !pready_i && !hit_o) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end
endmodule

// File: rtl/apb_req_master.sv
// -----------------------------------------------------------------------------
// apb_req_master
// Converts a req/gnt/rvalid request port into APB3 master transfers, one
// outstanding transfer at a time, 2 cycles per transfer back-to-back.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   bus           : apb_req_master_if.master (request port + APB port)
//   state_o       : current FSM state (debug visibility)
// Optional feature: define APB_REQ_MASTER_TIMEOUT_EN to abort an ACCESS phase
// after TIMEOUT_CYCLES wait cycles with an error response (rdata 0, err 1).
// -----------------------------------------------------------------------------
module apb_req_master
  import apb_req_master_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  apb_req_master_if.master      bus,
  output apb_state_e            state_o
);
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("apb_req_master: TIMEOUT_CYCLES must be >= 1");
  end

  apb_state_e                state_q;
  logic [APB_ADDR_WIDTH-1:0] paddr_q;
  logic [APB_DATA_WIDTH-1:0] pwdata_q;
  logic                      pwrite_q;
  logic                      psel_q;
  logic                      penable_q;
  logic                      rvalid_q;
  logic [APB_DATA_WIDTH-1:0] rdata_q;
  logic                      err_q;
  logic                      gnt;
  logic                      timeout_hit;

  // Accept in IDLE, or in the completing ACCESS cycle so the next transfer
  // starts its SETUP with no idle cycle in between.
  assign gnt = bus.req_i &&
               ((state_q == IDLE) || ((state_q == ACCESS) && bus.pready_i));

`ifdef APB_REQ_MASTER_TIMEOUT_EN
  apb_req_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clear_i  (state_q == SETUP),
    .access_i (state_q == ACCESS),
    .pready_i (bus.pready_i),
    .hit_o    (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      paddr_q   <= '0;
      pwdata_q  <= '0;
      pwrite_q  <= 1'b0;
      psel_q    <= 1'b0;
      penable_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      rvalid_q <= 1'b0;
      // Address/data/direction only change on an accepted request, which
      // keeps them stable from SETUP through the end of ACCESS.
      if (gnt) begin
        paddr_q  <= bus.addr_i;
        pwdata_q <= bus.wdata_i;
        pwrite_q <= bus.we_i;
      end
      case (state_q)
        IDLE: begin
          if (bus.req_i) begin
            state_q <= SETUP;
            psel_q  <= 1'b1;
          end
        end
        SETUP: begin
          state_q   <= ACCESS;
          penable_q <= 1'b1;
        end
        ACCESS: begin
          if (bus.pready_i) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= pwrite_q ? '0 : bus.prdata_i;
            err_q     <= bus.pslverr_i;
            penable_q <= 1'b0;
            if (bus.req_i) begin
              state_q <= SETUP;
              psel_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              psel_q  <= 1'b0;
            end
          end else if (timeout_hit) begin
            rvalid_q  <= 1'b1;
            rdata_q   <= '0;
            err_q     <= 1'b1;
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: begin
          state_q   <= IDLE;
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.gnt_o     = gnt;
  assign bus.rvalid_o  = rvalid_q;
  assign bus.rdata_o   = rdata_q;
  assign bus.err_o     = err_q;
  assign bus.paddr_o   = paddr_q;
  assign bus.pwdata_o  = pwdata_q;
  assign bus.pwrite_o  = pwrite_q;
  assign bus.psel_o    = psel_q;
  assign bus.penable_o = penable_q;
  assign state_o       = state_q;
endmodule
